// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back controller. Queues completed results in a small
// circular FIFO and drains them one at a time into the register file
// using a strobe/acknowledge handshake. Decode can ask whether a source
// register still has a write pending.
// Optional build macro WB_FORWARD_EN: when defined, q_rs1_fwd/q_rs2_fwd
// carry the youngest pending value for the queried register; otherwise
// they are tied to zero.

`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_WRITE
`define RF_WRITE 2'b01
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b10
`endif

module wb_ctrl #(
    parameter int unsigned LEN   = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy_in,
    input  logic           res_valid,
    input  logic [4:0]     res_rd,
    input  logic [LEN-1:0] res_data,
    output logic           res_ready,
    input  logic [4:0]     q_rs1,
    input  logic [4:0]     q_rs2,
    output logic           q_rs1_busy,
    output logic           q_rs2_busy,
    output logic [LEN-1:0] q_rs1_fwd,
    output logic [LEN-1:0] q_rs2_fwd,
    output logic [1:0]     rf_signal,
    output logic [4:0]     rf_rd,
    output logic [LEN-1:0] rf_data,
    output logic           write_back_enabled,
    input  logic [1:0]     rf_status
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t           state_q, state_d;
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [LEN-1:0]   data_q [DEPTH];
    logic [LEN-1:0]   data_d [DEPTH];
    logic             push;
    logic             pop;

    // Accept/pop decisions; ready depends on registered count only
    always_comb begin
        res_ready = rdy_in && !rst && (count_q < cnt_t'(DEPTH));
        push      = res_valid && res_ready && (res_rd != 5'd0);
        pop       = rdy_in && (state_q == WAIT_ACK) && (rf_status == `RF_FINISHED);
    end

    // Queue next-state: write at tail, retire at head, track occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (push) begin
            valid_d[tail_q] = 1'b1;
            rd_d[tail_q]    = res_rd;
            data_d[tail_q]  = res_data;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FSM next-state; a pop with work remaining goes straight back to ISSUE
    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            unique case (state_q)
                IDLE:     if (count_q != '0) state_d = ISSUE;
                ISSUE:    state_d = WAIT_ACK;
                WAIT_ACK: if (pop) state_d = (count_d != '0) ? ISSUE : IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Register-file command: one write strobe per ISSUE visit
    always_comb begin
        rf_signal          = `RF_NOP;
        write_back_enabled = 1'b0;
        rf_rd              = '0;
        rf_data            = '0;
        if (state_q == ISSUE) begin
            rf_signal          = `RF_WRITE;
            write_back_enabled = 1'b1;
            rf_rd              = rd_q[head_q];
            rf_data            = data_q[head_q];
        end
    end

    // Busy lookup over all valid entries; x0 is never busy
    always_comb begin
        q_rs1_busy = 1'b0;
        q_rs2_busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[ptr_t'(i)] && (rd_q[ptr_t'(i)] == q_rs1)) q_rs1_busy = 1'b1;
            if (valid_q[ptr_t'(i)] && (rd_q[ptr_t'(i)] == q_rs2)) q_rs2_busy = 1'b1;
        end
        if (q_rs1 == 5'd0) q_rs1_busy = 1'b0;
        if (q_rs2 == 5'd0) q_rs2_busy = 1'b0;
    end

`ifdef WB_FORWARD_EN
    // Forward lookup: scan oldest to youngest so the last match wins
    always_comb begin
        ptr_t idx;
        idx       = '0;
        q_rs1_fwd = '0;
        q_rs2_fwd = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + ptr_t'(i);
            if (valid_q[idx] && (rd_q[idx] == q_rs1) && (q_rs1 != 5'd0)) q_rs1_fwd = data_q[idx];
            if (valid_q[idx] && (rd_q[idx] == q_rs2) && (q_rs2 != 5'd0)) q_rs2_fwd = data_q[idx];
        end
    end
`else
    // Forwarding not built: outputs tied low
    always_comb begin
        q_rs1_fwd = '0;
        q_rs2_fwd = '0;
    end
`endif

    // Control state; reset abandons any in-flight write immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; meaning is governed by valid_q
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed and randomized checks of wb_ctrl against a
// timestamp-based reference model of the write-back queue.

`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_WRITE
`define RF_WRITE 2'b01
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b10
`endif

module tb_wb_ctrl;

    localparam int LEN   = 32;
    localparam int DEPTH = 4;
    localparam logic [1:0] NOP = `RF_NOP;
    localparam logic [1:0] WR  = `RF_WRITE;
    localparam logic [1:0] FIN = `RF_FINISHED;

    logic           clk = 1'b0;
    logic           rst, rdy_in, res_valid, res_ready;
    logic [4:0]     res_rd, q_rs1, q_rs2, rf_rd;
    logic [LEN-1:0] res_data, q_rs1_fwd, q_rs2_fwd, rf_data;
    logic           q_rs1_busy, q_rs2_busy, write_back_enabled;
    logic [1:0]     rf_signal, rf_status;

    wb_ctrl #(.LEN(LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_ready(res_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2),
        .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
        .q_rs1_fwd(q_rs1_fwd), .q_rs2_fwd(q_rs2_fwd),
        .rf_signal(rf_signal), .rf_rd(rf_rd), .rf_data(rf_data),
        .write_back_enabled(write_back_enabled), .rf_status(rf_status)
    );

    always #5 clk = ~clk;

    // Model: each queued result remembers the (enabled) cycle it was accepted
    // and, once at the head, the cycle its strobe is due.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          acc;
        int          strobe;
    } ent_t;

    ent_t mq[$];
    int   ec = 0;        // count of enabled (rdy_in high) cycles
    int   p_prev = -100; // enabled cycle of the most recent acknowledge
    bit   known = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int due(input int acc);
        // Head strobe: right after the previous ack if it was already waiting,
        // otherwise two enabled cycles after acceptance (via IDLE).
        return (acc <= p_prev) ? p_prev + 1 : acc + 2;
    endfunction

    task automatic step(input bit rs, input bit rdy, input bit v, input logic [4:0] rd,
                        input logic [31:0] d, input logic [1:0] st,
                        input logic [4:0] a1, input logic [4:0] a2);
        bit          ready_exp, strobe, b1, b2;
        logic [31:0] f1, f2;
        ent_t        e;
        rst = rs; rdy_in = rdy; res_valid = v; res_rd = rd; res_data = d;
        rf_status = st; q_rs1 = a1; q_rs2 = a2;
        #1;
        ready_exp = rdy && !rs && (mq.size() < DEPTH);
        strobe    = (mq.size() > 0) && (mq[0].strobe == ec);
        b1 = 1'b0; b2 = 1'b0; f1 = '0; f2 = '0;
        foreach (mq[i]) begin
            if (a1 != 5'd0 && mq[i].rd == a1) begin b1 = 1'b1; f1 = mq[i].data; end
            if (a2 != 5'd0 && mq[i].rd == a2) begin b2 = 1'b1; f2 = mq[i].data; end
        end
`ifndef WB_FORWARD_EN
        f1 = '0; f2 = '0;
`endif
        if (known) begin
            chk("res_ready", 32'(res_ready), 32'(ready_exp));
            chk("wbe", 32'(write_back_enabled), 32'(strobe));
            chk("rf_signal", 32'(rf_signal), strobe ? 32'(WR) : 32'(NOP));
            chk("rf_rd", 32'(rf_rd), strobe ? 32'(mq[0].rd) : 32'd0);
            chk("rf_data", rf_data, strobe ? mq[0].data : 32'd0);
            chk("rs1_busy", 32'(q_rs1_busy), 32'(b1));
            chk("rs2_busy", 32'(q_rs2_busy), 32'(b2));
            chk("rs1_fwd", q_rs1_fwd, f1);
            chk("rs2_fwd", q_rs2_fwd, f2);
        end
        @(posedge clk);
        if (rs) begin
            mq.delete();
            p_prev = -100;
            known  = 1'b1;
        end else if (rdy) begin
            if (mq.size() > 0 && ec > mq[0].strobe && st == FIN) begin
                void'(mq.pop_front());
                p_prev = ec;
                if (mq.size() > 0) mq[0].strobe = due(mq[0].acc);
            end
            if (ready_exp && v && rd != 5'd0) begin
                e.rd = rd; e.data = d; e.acc = ec;
                e.strobe = (mq.size() == 0) ? due(ec) : 32'h7fff_ffff;
                mq.push_back(e);
            end
            ec++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rdy_in = 1'b1; res_valid = 1'b0; res_rd = '0; res_data = '0;
        rf_status = NOP; q_rs1 = '0; q_rs2 = '0;
        @(negedge clk);

        // Reset, then reset-value check on the following cycle
        step(1, 1, 0, 0, 0, NOP, 0, 0);
        step(1, 1, 0, 0, 0, NOP, 5, 7);

        // Single write with ack one cycle after the strobe
        step(0, 1, 1, 5, 32'hDEADBEEF, FIN, 5, 0);
        repeat (5) step(0, 1, 0, 0, 0, FIN, 5, 0);

        // x0 result is discarded
        step(0, 1, 1, 0, 32'h1234, FIN, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0, FIN, 0, 0);

        // Fill past capacity with ack held off, then drain through the wrap
        for (int i = 0; i < 6; i++) step(0, 1, 1, 5'(i + 1), $urandom, NOP, 3, 4);
        repeat (14) step(0, 1, 0, 0, 0, FIN, 3, 4);

        // Two pending writes to the same register: youngest value forwards
        step(0, 1, 1, 7, 32'h1, NOP, 0, 7);
        step(0, 1, 1, 7, 32'h2, NOP, 0, 7);
        repeat (3) step(0, 1, 0, 0, 0, NOP, 0, 7);
        repeat (6) step(0, 1, 0, 0, 0, FIN, 0, 7);

        // Reset while waiting for an ack with three entries queued
        step(0, 1, 1, 9, 32'h90, NOP, 9, 10);
        step(0, 1, 1, 10, 32'ha0, NOP, 9, 10);
        step(0, 1, 1, 11, 32'hb0, NOP, 9, 11);
        step(0, 1, 0, 0, 0, NOP, 9, 10);
        step(1, 1, 0, 0, 0, NOP, 9, 10);
        repeat (4) step(0, 1, 0, 0, 0, FIN, 9, 10);

        // Stall for three cycles during ISSUE; offered result and ack ignored
        step(0, 1, 1, 12, 32'hCAFE0001, NOP, 12, 0);
        step(0, 1, 0, 0, 0, NOP, 12, 0);
        repeat (3) step(0, 0, 1, 13, 32'h5555, FIN, 12, 13);
        step(0, 1, 0, 0, 0, NOP, 12, 13);
        repeat (3) step(0, 1, 0, 0, 0, FIN, 12, 13);

        // Randomized traffic
        repeat (400) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
